// File: rtl/ibex_pmp_chk_sched.sv
// Round-robin scheduler that shares one PMP check channel among NumReq requesters. The response comes 2 cycles after accept and is held until rsp_ready_i when RspHold=1.
// Define IBEX_PMP_CHK_SCHED_FIXED_PRIO_EN for fixed priority, where the lowest index wins.
module ibex_pmp_chk_sched #(
   parameter int unsigned NumReq  = 2,
   parameter bit          RspHold = 1'b1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumReq-1:0]       req_valid_i,
   output logic [NumReq-1:0]       req_ready_o,
   input  logic [NumReq-1:0][33:0] req_addr_i,
   input  logic [NumReq-1:0][1:0]  req_type_i,
   input  logic [NumReq-1:0][1:0]  req_priv_i,
   output logic [NumReq-1:0]       rsp_valid_o,
   output logic                    rsp_err_o,
   input  logic [NumReq-1:0]       rsp_ready_i,
   output logic [33:0]             pmp_addr_o,
   output logic [1:0]              pmp_type_o,
   output logic [1:0]              pmp_priv_o,
   input  logic                    pmp_err_i,
   input  logic                    cfg_update_i,
   input  logic                    flush_i
);
   localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic [1:0] {IDLE, CHECK, RESP} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [33:0]     addr_q, addr_d;
   logic [1:0]      type_q, type_d;
   logic [1:0]      priv_q, priv_d;
   logic            err_q, err_d;
   logic            found;
   logic            grant;
   logic [IdxW-1:0] win_idx;

`ifdef IBEX_PMP_CHK_SCHED_FIXED_PRIO_EN
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      for (int i = 0; i < NumReq; i++) begin
         if (!found && req_valid_i[i]) begin
            found   = 1'b1;
            win_idx = IdxW'(i);
         end
      end
   end
`else
   logic [IdxW-1:0] ptr_q, ptr_d;
   logic [IdxW-1:0] cand;

   // Search starts at the pointer and wraps, so every waiting requester is reached within NumReq accepts.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int i = 0; i < NumReq; i++) begin
         cand = IdxW'((int'(ptr_q) + i) % int'(NumReq));
         if (!found && req_valid_i[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (grant) begin
         ptr_d = IdxW'((int'(win_idx) + 1) % int'(NumReq));
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      addr_d      = addr_q;
      type_d      = type_q;
      priv_d      = priv_q;
      err_d       = err_q;
      grant       = 1'b0;
      req_ready_o = '0;
      rsp_valid_o = '0;
      rsp_err_o   = 1'b0;
      pmp_addr_o  = '0;
      pmp_type_o  = '0;
      pmp_priv_o  = '0;
      unique case (state_q)
         IDLE: begin
            if (found && !flush_i) begin
               grant                = 1'b1;
               req_ready_o[win_idx] = 1'b1;
               idx_d                = win_idx;
               addr_d               = req_addr_i[win_idx];
               type_d               = req_type_i[win_idx];
               priv_d               = req_priv_i[win_idx];
               state_d              = CHECK;
            end
         end
         CHECK: begin
            pmp_addr_o = addr_q;
            pmp_type_o = type_q;
            pmp_priv_o = priv_q;
            // A CSR write this cycle may invalidate the checker result, so sample again next cycle.
            if (flush_i) begin
               state_d = IDLE;
            end else if (!cfg_update_i) begin
               err_d   = pmp_err_i;
               state_d = RESP;
            end
         end
         RESP: begin
            // Flush hides the response in this cycle so that no handshake can complete.
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               rsp_valid_o[idx_q] = 1'b1;
               rsp_err_o          = err_q;
               if (!RspHold || rsp_ready_i[idx_q]) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         addr_q  <= '0;
         type_q  <= '0;
         priv_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
         type_q  <= type_d;
         priv_q  <= priv_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ibex_pmp_chk_sched.sv
// Directed bench for ibex_pmp_chk_sched with NumReq=2 and RspHold=1. It replays a cycle table, then checks response latency with a bounded wait.
module tb_ibex_pmp_chk_sched;
   localparam logic [33:0] A0 = 34'h0_0000_1000;
   localparam logic [33:0] A1 = 34'h2_0000_0004;
   localparam logic [1:0]  T0 = 2'b10, P0 = 2'b11, T1 = 2'b01, P1 = 2'b01;
`ifdef IBEX_PMP_CHK_SCHED_FIXED_PRIO_EN
   localparam bit FP = 1'b1;
`else
   localparam bit FP = 1'b0;
`endif

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic [1:0]       req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
   logic [1:0][33:0] req_addr_i;
   logic [1:0][1:0]  req_type_i, req_priv_i;
   logic             rsp_err_o, pmp_err_i, cfg_update_i, flush_i;
   logic [33:0]      pmp_addr_o;
   logic [1:0]       pmp_type_o, pmp_priv_o;

   ibex_pmp_chk_sched #(.NumReq(2), .RspHold(1'b1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_type_i(req_type_i), .req_priv_i(req_priv_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_ready_i(rsp_ready_i),
      .pmp_addr_o(pmp_addr_o), .pmp_type_o(pmp_type_o), .pmp_priv_o(pmp_priv_o),
      .pmp_err_i(pmp_err_i), .cfg_update_i(cfg_update_i), .flush_i(flush_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic       rst;
      logic [1:0] vld;
      logic [1:0] rdy;
      logic       perr;
      logic       cfg;
      logic       fl;
      logic [1:0] e_rdy;
      logic [1:0] e_rsp;
      logic       e_err;
      int         e_sel;   // 0: channel idle, 1: request 0 on channel, 2: request 1
   } row_t;

   row_t rows[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic row_t mk(logic rst, logic [1:0] vld, logic [1:0] rdy, logic perr,
                               logic cfg, logic fl, logic [1:0] e_rdy, logic [1:0] e_rsp,
                               logic e_err, int e_sel);
      row_t r;
      r.rst = rst; r.vld = vld; r.rdy = rdy; r.perr = perr; r.cfg = cfg; r.fl = fl;
      r.e_rdy = e_rdy; r.e_rsp = e_rsp; r.e_err = e_err; r.e_sel = e_sel;
      return r;
   endfunction

   initial begin
      logic [1:0]  w1;
      int          s1;
      logic [33:0] ea;
      logic [1:0]  et, ep;
      int          lat;
      logic [1:0]  lat_rsp;
      logic        lat_err;

      w1 = FP ? 2'b01 : 2'b10;
      s1 = FP ? 1 : 2;

      // Single request, then a lone request 1 that wraps the pointer back to 0
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      rows.push_back(mk(1, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b01, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b10, 2'b00, 1, 0, 0, 2'b10, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 2));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b10, 1, 0));
      rows.push_back(mk(1, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b10, 1, 0));
      rows.push_back(mk(1, 2'b11, 2'b10, 0, 0, 0, 2'b00, 2'b10, 1, 0));
      // Both requesters held valid: 0,1,0,1 round-robin, always 0 with fixed priority
      for (int k = 0; k < 4; k++) begin
         rows.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, (k % 2 == 0) ? 2'b01 : w1, 2'b00, 0, 0));
         rows.push_back(mk(1, 2'b11, 2'b11, 0, 0, 0, 2'b00, 2'b00, 0, (k % 2 == 0) ? 1 : s1));
         rows.push_back(mk(1, (k == 3) ? 2'b00 : 2'b11, 2'b11, 0, 0, 0, 2'b00,
                           (k % 2 == 0) ? 2'b01 : w1, 0, 0));
      end
      // CSR-update stall: CHECK lasts 3 cycles and picks up the late error
      rows.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 1, 0, 2'b00, 2'b00, 0, 1));
      rows.push_back(mk(1, 2'b00, 2'b00, 1, 1, 0, 2'b00, 2'b00, 0, 1));
      rows.push_back(mk(1, 2'b00, 2'b00, 1, 0, 0, 2'b00, 2'b00, 0, 1));
      // Response held for 5 cycles while the other requester waits
      for (int k = 0; k < 5; k++)
         rows.push_back(mk(1, 2'b10, 2'b00, 0, 0, 0, 2'b00, 2'b01, 1, 0));
      rows.push_back(mk(1, 2'b10, 2'b01, 0, 0, 0, 2'b00, 2'b01, 1, 0));
      rows.push_back(mk(1, 2'b10, 2'b00, 0, 0, 0, 2'b10, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 2));
      // Flush in RESP, in IDLE, and in CHECK together with a CSR update
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b01, 2'b00, 0, 0, 1, 2'b00, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 1, 1, 1, 2'b00, 2'b00, 0, 1));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      // Reset during CHECK drops the request and returns the pointer to 0
      rows.push_back(mk(1, 2'b01, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      rows.push_back(mk(0, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b11, 2'b00, 0, 0, 0, 2'b01, 2'b00, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 1));
      rows.push_back(mk(1, 2'b00, 2'b01, 0, 0, 0, 2'b00, 2'b01, 0, 0));
      rows.push_back(mk(1, 2'b00, 2'b00, 0, 0, 0, 2'b00, 2'b00, 0, 0));

      req_addr_i[0] = A0; req_type_i[0] = T0; req_priv_i[0] = P0;
      req_addr_i[1] = A1; req_type_i[1] = T1; req_priv_i[1] = P1;
      rst_ni = 1'b0; req_valid_i = '0; rsp_ready_i = '0;
      pmp_err_i = 1'b0; cfg_update_i = 1'b0; flush_i = 1'b0;
      repeat (2) @(negedge clk_i);

      for (int i = 0; i < rows.size(); i++) begin
         if (i > 0) @(negedge clk_i);
         rst_ni       = rows[i].rst;
         req_valid_i  = rows[i].vld;
         rsp_ready_i  = rows[i].rdy;
         pmp_err_i    = rows[i].perr;
         cfg_update_i = rows[i].cfg;
         flush_i      = rows[i].fl;
         #2;
         ea = (rows[i].e_sel == 1) ? A0 : (rows[i].e_sel == 2) ? A1 : 34'h0;
         et = (rows[i].e_sel == 1) ? T0 : (rows[i].e_sel == 2) ? T1 : 2'b00;
         ep = (rows[i].e_sel == 1) ? P0 : (rows[i].e_sel == 2) ? P1 : 2'b00;
         n_tests++;
         if (req_ready_o !== rows[i].e_rdy || rsp_valid_o !== rows[i].e_rsp ||
             rsp_err_o !== rows[i].e_err || pmp_addr_o !== ea ||
             pmp_type_o !== et || pmp_priv_o !== ep) begin
            n_fail++;
            $display("FAIL row %0d: got rdy=%b rsp=%b err=%b addr=%h type=%b priv=%b, want rdy=%b rsp=%b err=%b addr=%h type=%b priv=%b",
                     i, req_ready_o, rsp_valid_o, rsp_err_o, pmp_addr_o, pmp_type_o, pmp_priv_o,
                     rows[i].e_rdy, rows[i].e_rsp, rows[i].e_err, ea, et, ep);
         end
      end

      // Response latency from the accept cycle, with a bounded wait
      @(negedge clk_i);
      rst_ni = 1'b1; req_valid_i = 2'b10; rsp_ready_i = 2'b10;
      pmp_err_i = 1'b1; cfg_update_i = 1'b0; flush_i = 1'b0;
      lat = -1; lat_rsp = '0; lat_err = 1'b0;
      for (int c = 0; c < 10; c++) begin
         #2;
         if (lat < 0 && rsp_valid_o != 2'b00) begin
            lat = c; lat_rsp = rsp_valid_o; lat_err = rsp_err_o;
         end
         @(negedge clk_i);
         req_valid_i = 2'b00;
      end
      n_tests++;
      if (lat < 0) begin
         n_fail++;
         $display("FAIL latency: no response within 10 cycles, want one after 2");
      end else if (lat != 2 || lat_rsp !== 2'b10 || lat_err !== 1'b1) begin
         n_fail++;
         $display("FAIL latency: got %0d cycles rsp=%b err=%b, want 2 cycles rsp=10 err=1",
                  lat, lat_rsp, lat_err);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ibex_pmp_chk_sched.md
IBEX_PMP_CHK_SCHED -- requirements
Module: ibex_pmp_chk_sched

Interface
REQ-001 Parameter NumReq, default 2, SHALL set the number of requesters sharing one PMP check channel (2..4).
REQ-002 Parameter RspHold, default 1, SHALL hold rsp_valid_o until rsp_ready_i when 1; when 0, the response lasts one cycle and rsp_ready_i is ignored.
REQ-003 clk_i  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_ni  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid_i  in  NumReq  SHALL be the per-requester check request.
REQ-006 req_ready_o  out  NumReq  SHALL mark request acceptance (one-hot or zero).
REQ-007 req_addr_i  in  NumReq x 34  SHALL be the physical address per requester.
REQ-008 req_type_i  in  NumReq x 2  SHALL be the access type per requester (exec/write/read encoding of the PMP request type).
REQ-009 req_priv_i  in  NumReq x 2  SHALL be the privilege level per requester.
REQ-010 rsp_valid_o  out  NumReq  SHALL mark the response for the owning requester (one-hot or zero).
REQ-011 rsp_err_o  out  1  SHALL be the access-fault result, meaningful only while some rsp_valid_o bit is 1.
REQ-012 rsp_ready_i  in  NumReq  SHALL be per-requester response acceptance.
REQ-013 pmp_addr_o / pmp_type_o / pmp_priv_o  out  34 / 2 / 2  SHALL drive the shared PMP checker channel.
REQ-014 pmp_err_i  in  1  SHALL be the combinational fault result of the shared checker.
REQ-015 cfg_update_i  in  1  SHALL pulse when any PMP cfg/addr/mseccfg CSR is written.
REQ-016 flush_i  in  1  SHALL abort any in-flight check.

Function
REQ-017 FSM states SHALL be IDLE, CHECK, RESP.
REQ-018 In IDLE, req_ready_o SHALL equal the arbiter grant: one-hot on the winning valid requester, zero if none is valid; all other states drive req_ready_o to zero.
REQ-019 On accept, addr/type/priv and requester index SHALL be registered and the FSM SHALL move to CHECK.
REQ-020 In CHECK, pmp_*_o SHALL reflect the registered request; in all other states they SHALL be zero.
REQ-021 In CHECK without cfg_update_i, pmp_err_i SHALL be captured and the FSM SHALL move to RESP.
REQ-022 In CHECK with cfg_update_i, the FSM SHALL stay in CHECK and re-sample next cycle, so the result never uses stale CSRs.
REQ-023 In RESP, rsp_valid_o SHALL be set only at the registered index and rsp_err_o SHALL equal the captured bit.
REQ-024 RESP SHALL exit to IDLE on rsp_ready_i[index]; with RspHold=0 it SHALL exit after one cycle.
REQ-025 Latency SHALL be exactly 2 cycles: accept in cycle N, CHECK in N+1, rsp_valid_o in N+2, barring cfg_update_i stalls.
REQ-026 Arbitration SHALL be round-robin: the pointer moves to winner+1 (mod NumReq) on each accept, and the search starts at the pointer.
REQ-027 flush_i SHALL take priority over cfg_update_i and rsp_ready_i: from CHECK or RESP the FSM SHALL go to IDLE, no response is issued and the dropped request is not retried; in IDLE it SHALL block acceptance that cycle.
REQ-028 A requester holding req_valid_i while unaccepted SHALL NOT be starved: with round-robin, acceptance is guaranteed within NumReq accepts.
REQ-029 A new request SHALL NOT be accepted in the same cycle a response completes; the next accept is earliest in the following IDLE cycle.

Reset
REQ-030 While rst_ni=0 at a clock edge, the FSM SHALL go to IDLE, the round-robin pointer to 0, and the captured error and registered request to 0.
REQ-031 After reset, all outputs SHALL be 0 in IDLE except req_ready_o, which follows REQ-018; reset mid-operation SHALL drop the request without a response.

Configuration
REQ-032 With macro IBEX_PMP_CHK_SCHED_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the pointer SHALL be removed; without it, REQ-026 round-robin applies.

Verification
REQ-033 Single request: req_valid_i=01, addr 0x1000, pmp_err_i=0 -> req_ready_o=01 at N, pmp_addr_o=0x1000 at N+1, rsp_valid_o=01 and rsp_err_o=0 at N+2.
REQ-034 Contention in round-robin build: req_valid_i=11 held continuously -> accept order 0,1,0,1; in the FIXED_PRIO build -> 0,0,0.
REQ-035 cfg_update_i high for 2 cycles during CHECK, pmp_err_i 0->1 on the last cycle -> CHECK lasts 3 cycles and rsp_err_o=1.
REQ-036 flush_i in RESP while rsp_ready_i=0 -> rsp_valid_o=0 next cycle, FSM in IDLE, no response delivered.
REQ-037 RspHold=1, rsp_ready_i low for 5 cycles -> rsp_valid_o and rsp_err_o stable for 5 cycles and req_ready_o=0 throughout.
REQ-038 rst_ni=0 for one edge during CHECK -> next cycle all outputs 0 and the pointer at 0.
